// File: rtl/pio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pio_pkg
// Purpose  : Shared definitions for the Avalon-MM PIO bank: register word
//            addresses, edge-detection mode encoding and the INFO magic byte.
// Revision : 1.0  initial release
// ============================================================================
package pio_pkg;

   localparam logic [2:0] ADDR_DATA_IN   = 3'd0;
   localparam logic [2:0] ADDR_DATA_OUT  = 3'd1;
   localparam logic [2:0] ADDR_EDGE_CAP  = 3'd2;
   localparam logic [2:0] ADDR_IRQ_MASK  = 3'd3;
   localparam logic [2:0] ADDR_OUT_SET   = 3'd4;
   localparam logic [2:0] ADDR_OUT_CLR   = 3'd5;
   localparam logic [2:0] ADDR_EDGE_MODE = 3'd6;
   localparam logic [2:0] ADDR_INFO      = 3'd7;

   // Encoding 3 is not named; the edge logic treats it as "both".
   typedef enum logic [1:0] {
      EM_RISE = 2'd0,
      EM_FALL = 2'd1,
      EM_BOTH = 2'd2
   } edge_mode_e;

   localparam logic [7:0] INFO_MAGIC = 8'h50;

endpackage
`default_nettype wire

// File: rtl/pio_debounce.sv
`default_nettype none
// ============================================================================
// Module   : pio_debounce
// Purpose  : Per-bit input conditioning: synchroniser, optional prescaled
//            debouncer and the debounced-value register with its primed flag.
// Config   : PIO_DEBOUNCE_EN  - when defined, a free-running prescaler
//            (0..DEB_CYCLES-1) samples the synchroniser and a bit only
//            changes after two consecutive agreeing samples. When undefined
//            the debounced register is the second synchroniser stage.
// Ports    : clk        system clock
//            rst        asynchronous active-high reset
//            i_in       asynchronous inputs, W bits
//            o_deb      debounced value (registered)
//            o_deb_nxt  value o_deb will take at the next clock edge
//            o_primed   set once the first qualified sample has been loaded
// Revision : 1.0  initial release
// ============================================================================
module pio_debounce
   import pio_pkg::*;
#(
   parameter int W          = 8,
   parameter int DEB_CYCLES = 50000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] i_in,
   output logic [W-1:0] o_deb,
   output logic [W-1:0] o_deb_nxt,
   output logic         o_primed
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_deb;
   logic         r_primed;
   logic [W-1:0] w_deb_nxt;
   logic         w_prime;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_meta <= '0;
      else     r_meta <= i_in;
   end

`ifdef PIO_DEBOUNCE_EN
   localparam int CW = $clog2(DEB_CYCLES);

   logic [W-1:0]  r_sync;
   logic [CW-1:0] r_cnt;
   logic [W-1:0]  r_samp;
   logic          r_samp_vld;
   logic          w_tick;
   logic [W-1:0]  w_agree;

   assign w_tick  = (r_cnt == CW'(DEB_CYCLES - 1));
   // Bits whose current synchronised value matches the previous tick sample.
   assign w_agree = ~(r_sync ^ r_samp);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync     <= '0;
         r_cnt      <= '0;
         r_samp     <= '0;
         r_samp_vld <= 1'b0;
      end else begin
         r_sync <= r_meta;
         if (w_tick) begin
            r_cnt      <= '0;
            r_samp     <= r_sync;
            r_samp_vld <= 1'b1;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   // r_samp_vld stops the reset value of r_samp from being taken as a real
   // sample. Priming waits until every bit agrees so the whole register is
   // loaded from a consistent snapshot.
   always_comb begin
      w_deb_nxt = r_deb;
      w_prime   = 1'b0;
      if (w_tick && r_samp_vld) begin
         if (!r_primed) begin
            if (&w_agree) begin
               w_deb_nxt = r_sync;
               w_prime   = 1'b1;
            end
         end else begin
            w_deb_nxt = (r_deb & ~w_agree) | (r_sync & w_agree);
         end
      end
   end
`else
   logic r_meta_vld;

   // r_meta holds a real input sample only after its first clock; priming
   // from it earlier would load reset zeros and fake a rising edge later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_meta_vld <= 1'b0;
      else     r_meta_vld <= 1'b1;
   end

   always_comb begin
      w_deb_nxt = r_meta_vld ? r_meta : r_deb;
      w_prime   = r_meta_vld && !r_primed;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_deb    <= '0;
         r_primed <= 1'b0;
      end else begin
         r_deb <= w_deb_nxt;
         if (w_prime) r_primed <= 1'b1;
      end
   end

   assign o_deb     = r_deb;
   assign o_deb_nxt = w_deb_nxt;
   assign o_primed  = r_primed;

endmodule
`default_nettype wire

// File: rtl/avmm_pio_bank.sv
`default_nettype none
// ============================================================================
// Module   : avmm_pio_bank
// Purpose  : Avalon-MM PIO peripheral: conditioned inputs with per-bit edge
//            capture, outputs with atomic set/clear and one maskable level IRQ.
// Config   : PIO_DEBOUNCE_EN  - enables the prescaled input debouncer and
//            reports DEB_EN=1 in INFO[23:16].
// Ports    : clk            system clock
//            reset          asynchronous active-high reset
//            avs_address    word address (3 bits)
//            avs_read       read strobe, readdata valid one cycle later
//            avs_write      write strobe, takes effect on the write cycle
//            avs_writedata  write data (32 bits)
//            avs_readdata   registered read data (32 bits)
//            pio_in         asynchronous external inputs, IN_WIDTH bits
//            pio_out        registered outputs, OUT_WIDTH bits
//            irq            registered level interrupt
// Revision : 1.0  initial release
// ============================================================================
module avmm_pio_bank
   import pio_pkg::*;
#(
   parameter int                   IN_WIDTH      = 8,
   parameter int                   OUT_WIDTH     = 32,
   parameter logic [OUT_WIDTH-1:0] OUT_RESET_VAL = '0,
   parameter int                   DEB_CYCLES    = 50000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [2:0]           avs_address,
   input  logic                 avs_read,
   input  logic                 avs_write,
   input  logic [31:0]          avs_writedata,
   output logic [31:0]          avs_readdata,
   input  logic [IN_WIDTH-1:0]  pio_in,
   output logic [OUT_WIDTH-1:0] pio_out,
   output logic                 irq
);

`ifdef PIO_DEBOUNCE_EN
   localparam int c_deb_en = 1;
`else
   localparam int c_deb_en = 0;
`endif

   logic [31:0]          r_rdata;
   logic [OUT_WIDTH-1:0] r_out;
   logic [IN_WIDTH-1:0]  r_ecap;
   logic [IN_WIDTH-1:0]  r_mask;
   logic [1:0]           r_emode;
   logic                 r_irq;

   logic [IN_WIDTH-1:0]  w_deb;
   logic [IN_WIDTH-1:0]  w_deb_nxt;
   logic                 w_primed;
   logic [IN_WIDTH-1:0]  w_chg;
   logic [IN_WIDTH-1:0]  w_cap;
   logic [IN_WIDTH-1:0]  w_w1c;
   logic [31:0]          w_rdata;

   pio_debounce #(
      .W          (IN_WIDTH),
      .DEB_CYCLES (DEB_CYCLES)
   ) u_deb (
      .clk       (clk),
      .rst       (reset),
      .i_in      (pio_in),
      .o_deb     (w_deb),
      .o_deb_nxt (w_deb_nxt),
      .o_primed  (w_primed)
   );

   // Edges are taken from the value about to be loaded so EDGE_CAP sets on
   // the same clock as the debounced register. The priming load is excluded.
   assign w_chg = w_primed ? (w_deb_nxt ^ w_deb) : '0;

   always_comb begin
      w_cap = '0;
      case (r_emode)
         EM_RISE: w_cap = w_chg & w_deb_nxt;
         EM_FALL: w_cap = w_chg & ~w_deb_nxt;
         default: w_cap = w_chg;
      endcase
   end

   assign w_w1c = (avs_write && (avs_address == ADDR_EDGE_CAP))
                  ? avs_writedata[IN_WIDTH-1:0] : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out   <= OUT_RESET_VAL;
         r_mask  <= '0;
         r_emode <= '0;
      end else if (avs_write) begin
         case (avs_address)
            ADDR_DATA_OUT:  r_out   <= avs_writedata[OUT_WIDTH-1:0];
            ADDR_OUT_SET:   r_out   <= r_out | avs_writedata[OUT_WIDTH-1:0];
            ADDR_OUT_CLR:   r_out   <= r_out & ~avs_writedata[OUT_WIDTH-1:0];
            ADDR_IRQ_MASK:  r_mask  <= avs_writedata[IN_WIDTH-1:0];
            ADDR_EDGE_MODE: r_emode <= avs_writedata[1:0];
            default: ;
         endcase
      end
   end

   // A new edge in the same cycle as its W1C wins: set is applied after clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ecap <= '0;
         r_irq  <= 1'b0;
      end else begin
         r_ecap <= (r_ecap & ~w_w1c) | w_cap;
         r_irq  <= |(r_ecap & r_mask);
      end
   end

   always_comb begin
      w_rdata = '0;
      case (avs_address)
         ADDR_DATA_IN:   w_rdata = 32'(w_deb);
         ADDR_DATA_OUT:  w_rdata = 32'(r_out);
         ADDR_EDGE_CAP:  w_rdata = 32'(r_ecap);
         ADDR_IRQ_MASK:  w_rdata = 32'(r_mask);
         ADDR_EDGE_MODE: w_rdata = 32'(r_emode);
         ADDR_INFO:      w_rdata = {INFO_MAGIC, 8'(c_deb_en), 8'(OUT_WIDTH), 8'(IN_WIDTH)};
         default:        w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)         r_rdata <= '0;
      else if (avs_read) r_rdata <= w_rdata;
   end

   assign avs_readdata = r_rdata;
   assign pio_out      = r_out;
   assign irq          = r_irq;

endmodule
`default_nettype wire
